// File: rtl/chan_occupancy_detect_if.sv
// ---------------------------------------------------------------------------
// chan_occupancy_detect_if
//  Groups the three AXI-stream style channels of chan_occupancy_detect:
//   i_*        : averaged bin-power stream in (tdata = power word, tlast = last bin)
//   o_*        : channel record stream out (tdata = {occupied, chan_idx, peak_pwr})
//   i_config_* : configuration strobe (tdata = {threshold, bins_per_chan})
//  master : the side that feeds bins/config and consumes records (upstream/bench)
//  slave  : the detector itself
// ---------------------------------------------------------------------------
interface chan_occupancy_detect_if #(
   parameter int WIDTH    = 32,
   parameter int BPC_LOG2 = 8,
   parameter int CHAN_W   = 8
);
   logic [WIDTH-1:0]          i_tdata;
   logic                      i_tlast;
   logic                      i_tvalid;
   logic                      i_tready;
   logic [CHAN_W+WIDTH:0]     o_tdata;
   logic                      o_tlast;
   logic                      o_tvalid;
   logic                      o_tready;
   logic [WIDTH+BPC_LOG2:0]   i_config_tdata;
   logic                      i_config_tvalid;
   logic                      i_config_tready;

   modport master (
      output i_tdata, i_tlast, i_tvalid,
      input  i_tready,
      input  o_tdata, o_tlast, o_tvalid,
      output o_tready,
      output i_config_tdata, i_config_tvalid,
      input  i_config_tready
   );

   modport slave (
      input  i_tdata, i_tlast, i_tvalid,
      output i_tready,
      output o_tdata, o_tlast, o_tvalid,
      input  o_tready,
      input  i_config_tdata, i_config_tvalid,
      output i_config_tready
   );
endinterface

// File: rtl/chan_occupancy_detect.sv
// ---------------------------------------------------------------------------
// chan_occupancy_detect
//  Groups consecutive FFT bins of an averaged power packet into channels of
//  bins_per_chan bins, tracks the peak power of each channel and emits one
//  record per channel: {occupied, chan_idx, peak_pwr}, occupied meaning
//  peak_pwr > threshold. The record for the last channel of a packet
//  (possibly a partial channel) carries o_tlast.
// Ports
//  clk, reset_n : clock, synchronous active-low reset
//  bus.i_*      : bin power stream in (one WIDTH-bit word per bin)
//  bus.o_*      : channel record stream out, one output register
//  bus.i_config_*: {threshold, bins_per_chan} strobe, always accepted
// ---------------------------------------------------------------------------
module chan_occupancy_detect #(
   parameter int WIDTH    = 32,
   parameter int BPC_LOG2 = 8,
   parameter int CHAN_W   = 8
) (
   input logic                   clk,
   input logic                   reset_n,
   chan_occupancy_detect_if.slave bus
);
   localparam int BPC_W = BPC_LOG2 + 1;
   localparam int REC_W = 1 + CHAN_W + WIDTH;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [BPC_W-1:0]   bin_cnt_q, bin_cnt_d;
   logic [CHAN_W-1:0]  chan_idx_q, chan_idx_d;
   logic [WIDTH-1:0]   peak_q, peak_d;
   // staging copies written by the config strobe at any time
   logic [WIDTH-1:0]   threshold_reg_q, threshold_reg_d;
   logic [BPC_W-1:0]   bpc_reg_q, bpc_reg_d;
   // active copies, frozen for the duration of a packet
   logic [WIDTH-1:0]   threshold_q, threshold_d;
   logic [BPC_W-1:0]   bpc_q, bpc_d;
   logic               o_tvalid_q, o_tvalid_d;
   logic               o_tlast_q, o_tlast_d;
   logic [REC_W-1:0]   o_tdata_q, o_tdata_d;

   logic               in_ready;
   logic               accept;
   logic [WIDTH-1:0]   thr_use;
   logic [BPC_W-1:0]   bpc_raw;
   logic [BPC_W-1:0]   bpc_use;
   logic [WIDTH-1:0]   peak_next;
   logic               chan_close;

   assign in_ready            = ~o_tvalid_q | bus.o_tready;
   assign accept              = bus.i_tvalid & in_ready;
   assign bus.i_tready        = in_ready;
   assign bus.i_config_tready = 1'b1;
   assign bus.o_tvalid        = o_tvalid_q;
   assign bus.o_tlast         = o_tlast_q;
   assign bus.o_tdata         = o_tdata_q;

   always_comb begin
      state_d         = state_q;
      bin_cnt_d       = bin_cnt_q;
      chan_idx_d      = chan_idx_q;
      peak_d          = peak_q;
      threshold_reg_d = threshold_reg_q;
      bpc_reg_d       = bpc_reg_q;
      threshold_d     = threshold_q;
      bpc_d           = bpc_q;
      o_tvalid_d      = o_tvalid_q & ~bus.o_tready;
      o_tlast_d       = o_tlast_q;
      o_tdata_d       = o_tdata_q;

      if (bus.i_config_tvalid) begin
         threshold_reg_d = bus.i_config_tdata[WIDTH+BPC_LOG2:BPC_W];
         bpc_reg_d       = bus.i_config_tdata[BPC_LOG2:0];
      end

      // In IDLE the first beat uses the staging value including a strobe
      // arriving in the same cycle; afterwards only the frozen copy counts.
      if (state_q == ST_IDLE) begin
         thr_use = threshold_reg_d;
         bpc_raw = bpc_reg_d;
      end else begin
         thr_use = threshold_q;
         bpc_raw = bpc_q;
      end
      bpc_use = (bpc_raw == '0) ? BPC_W'(1) : bpc_raw;

      peak_next = peak_q;
      if (bin_cnt_q == '0 || bus.i_tdata > peak_q) begin
         peak_next = bus.i_tdata;
      end
      chan_close = (bin_cnt_q == bpc_use - 1'b1) | bus.i_tlast;

      if (accept) begin
         case (state_q)
            ST_IDLE: begin
               threshold_d = thr_use;
               bpc_d       = bpc_use;
               state_d     = bus.i_tlast ? ST_IDLE : ST_ACCUM;
            end
            default: begin
               if (bus.i_tlast) begin
                  state_d = ST_IDLE;
               end
            end
         endcase

         if (chan_close) begin
            o_tvalid_d = 1'b1;
            o_tlast_d  = bus.i_tlast;
            o_tdata_d  = {peak_next > thr_use, chan_idx_q, peak_next};
            bin_cnt_d  = '0;
            chan_idx_d = bus.i_tlast ? '0 : chan_idx_q + 1'b1;
         end else begin
            bin_cnt_d  = bin_cnt_q + 1'b1;
            peak_d     = peak_next;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q         <= ST_IDLE;
         bin_cnt_q       <= '0;
         chan_idx_q      <= '0;
         peak_q          <= '0;
         threshold_reg_q <= '0;
         bpc_reg_q       <= BPC_W'(1);
         threshold_q     <= '0;
         bpc_q           <= BPC_W'(1);
         o_tvalid_q      <= 1'b0;
         o_tlast_q       <= 1'b0;
         o_tdata_q       <= '0;
      end else begin
         state_q         <= state_d;
         bin_cnt_q       <= bin_cnt_d;
         chan_idx_q      <= chan_idx_d;
         peak_q          <= peak_d;
         threshold_reg_q <= threshold_reg_d;
         bpc_reg_q       <= bpc_reg_d;
         threshold_q     <= threshold_d;
         bpc_q           <= bpc_d;
         o_tvalid_q      <= o_tvalid_d;
         o_tlast_q       <= o_tlast_d;
         o_tdata_q       <= o_tdata_d;
      end
   end
endmodule

// File: tb/tb_chan_occupancy_detect.sv
// ---------------------------------------------------------------------------
// tb_chan_occupancy_detect
//  Drives bin packets and config strobes into chan_occupancy_detect and
//  compares every emitted record against a packet-level reference model that
//  chunks each packet into channels and takes the maximum of each chunk.
// ---------------------------------------------------------------------------
module tb_chan_occupancy_detect;
   localparam int WIDTH    = 32;
   localparam int BPC_LOG2 = 8;
   localparam int CHAN_W   = 8;
   localparam int BPC_W    = BPC_LOG2 + 1;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   chan_occupancy_detect_if #(.WIDTH(WIDTH), .BPC_LOG2(BPC_LOG2), .CHAN_W(CHAN_W)) bus ();

   chan_occupancy_detect #(.WIDTH(WIDTH), .BPC_LOG2(BPC_LOG2), .CHAN_W(CHAN_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, act, exp);
   endtask

   // ---------------- reference model ----------------
   logic [63:0]      exp_q[$];
   logic [WIDTH-1:0] pkt[$];
   logic [WIDTH-1:0] cfg_thr = '0;
   int               cfg_bpc = 1;

   function automatic void model_packet();
      int bpc;
      int n;
      int ch;
      bpc = (cfg_bpc == 0) ? 1 : cfg_bpc;
      n   = pkt.size();
      ch  = 0;
      for (int s = 0; s < n; s += bpc) begin
         int e;
         logic [WIDTH-1:0] pk;
         logic [63:0] r;
         e  = (s + bpc < n) ? s + bpc : n;
         pk = '0;
         for (int i = s; i < e; i++) if (pkt[i] > pk) pk = pkt[i];
         r = '0;
         r[WIDTH-1:0]            = pk;
         r[WIDTH +: CHAN_W]      = ch[CHAN_W-1:0];
         r[WIDTH+CHAN_W]         = (pk > cfg_thr);
         r[WIDTH+CHAN_W+1]       = (e == n);
         exp_q.push_back(r);
         ch++;
      end
   endfunction

   // ---------------- output side: ready generation and monitor ----------------
   int          rdy_mode = 1;   // 0 random, 1 always, 2 never, 3 pattern 1-0-0-1
   int          cyc = 0;
   logic        mon_en = 1'b0;
   logic        prev_stall = 1'b0;
   logic [63:0] prev_out = '0;
   logic [63:0] mon_act;

   initial begin
      bus.o_tready = 1'b0;
      forever begin
         @(negedge clk);
         case (rdy_mode)
            0:       bus.o_tready = ($urandom_range(0, 3) != 0);
            2:       bus.o_tready = 1'b0;
            3:       bus.o_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: bus.o_tready = 1'b1;
         endcase
         cyc++;
         #1;
         if (mon_en) begin
            mon_act = 64'({bus.o_tlast, bus.o_tdata});
            if (prev_stall) begin
               check("hold_valid", 64'(bus.o_tvalid), 64'(1));
               check("hold_data", mon_act, prev_out);
            end
            if (bus.o_tvalid && !bus.o_tready) check("stall_iready", 64'(bus.i_tready), 64'(0));
            if (!bus.o_tvalid) check("idle_iready", 64'(bus.i_tready), 64'(1));
            if (bus.o_tvalid && bus.o_tready) begin
               if (exp_q.size() == 0) check("unexpected_rec", mon_act, 64'(0) - 64'(1));
               else check("record", mon_act, exp_q.pop_front());
            end
            prev_stall = bus.o_tvalid && !bus.o_tready;
            prev_out   = mon_act;
         end else begin
            prev_stall = 1'b0;
         end
      end
   end

   // ---------------- input side tasks ----------------
   task automatic set_cfg(input logic [WIDTH-1:0] thr, input int bpc);
      @(negedge clk);
      bus.i_tvalid        = 1'b0;
      bus.i_config_tdata  = {thr, BPC_W'(bpc)};
      bus.i_config_tvalid = 1'b1;
      cfg_thr = thr;
      cfg_bpc = bpc;
   endtask

   task automatic drive_beat(input logic [WIDTH-1:0] d, input logic l, input logic cfg_en, input int gap);
      int n;
      repeat (gap) begin
         @(negedge clk);
         bus.i_tvalid        = 1'b0;
         bus.i_config_tvalid = 1'b0;
      end
      @(negedge clk);
      bus.i_tdata         = d;
      bus.i_tlast         = l;
      bus.i_tvalid        = 1'b1;
      bus.i_config_tvalid = cfg_en;
      if (cfg_en) bus.i_config_tdata = {cfg_thr, BPC_W'(cfg_bpc)};
      #1;
      n = 0;
      while (!bus.i_tready) begin
         n++;
         if (n > 500) begin
            check("accept_timeout", 64'(0), 64'(1));
            break;
         end
         @(negedge clk);
         #1;
      end
      @(posedge clk);
   endtask

   task automatic end_drive();
      @(negedge clk);
      bus.i_tvalid        = 1'b0;
      bus.i_config_tvalid = 1'b0;
   endtask

   // coinc: config strobe rides the first beat; mid_k > 0: new config before beat mid_k
   task automatic send_pkt(input logic coinc, input int mid_k, input logic [WIDTH-1:0] mthr,
                           input int mbpc, input logic gaps);
      for (int i = 0; i < pkt.size(); i++) begin
         if (mid_k > 0 && i == mid_k) set_cfg(mthr, mbpc);
         drive_beat(pkt[i], (i == pkt.size() - 1), coinc && (i == 0),
                    (gaps && $urandom_range(0, 2) == 0) ? 1 : 0);
      end
      end_drive();
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("drain_left", 64'(exp_q.size()), 64'(0));
   endtask

   task automatic load_t1();
      logic [WIDTH-1:0] t1 [16] = '{10, 200, 30, 40, 5, 6, 7, 8, 101, 0, 0, 0, 100, 100, 100, 100};
      pkt.delete();
      foreach (t1[i]) pkt.push_back(t1[i]);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      bus.i_tdata = '0; bus.i_tlast = 1'b0; bus.i_tvalid = 1'b0;
      bus.i_config_tdata = '0; bus.i_config_tvalid = 1'b0;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ovalid", 64'(bus.o_tvalid), 64'(0));
      check("rst_otlast", 64'(bus.o_tlast), 64'(0));
      check("rst_odata", 64'(bus.o_tdata), 64'(0));
      check("cfg_tready", 64'(bus.i_config_tready), 64'(1));
      reset_n = 1'b1;
      mon_en  = 1'b1;

      // default config after reset: thr 0, one bin per channel
      pkt = '{0, 5, 1};
      model_packet(); send_pkt(1'b0, 0, '0, 0, 1'b0); drain();

      // T1
      rdy_mode = 1;
      set_cfg(100, 4); load_t1();
      model_packet(); send_pkt(1'b0, 0, '0, 0, 1'b0); drain();

      // T2: partial last channel
      set_cfg(49, 3);
      pkt = '{50, 50, 50, 50, 50, 50, 50, 50};
      model_packet(); send_pkt(1'b0, 0, '0, 0, 1'b0); drain();

      // T3: output back-pressure pattern
      rdy_mode = 3;
      set_cfg(100, 4); load_t1();
      model_packet(); send_pkt(1'b0, 0, '0, 0, 1'b0); drain();

      // T4: mid-packet config change applies only to the next packet
      rdy_mode = 0;
      set_cfg(100, 4);
      pkt.delete();
      for (int i = 0; i < 12; i++) pkt.push_back($urandom_range(0, 200));
      model_packet(); send_pkt(1'b0, 5, 120, 2, 1'b1);
      pkt.delete();
      for (int i = 0; i < 6; i++) pkt.push_back($urandom_range(0, 200));
      model_packet(); send_pkt(1'b0, 0, '0, 0, 1'b0); drain();

      // T5: bpc 0 behaves as 1
      rdy_mode = 1;
      set_cfg(2, 0);
      pkt = '{1, 2, 3};
      model_packet(); send_pkt(1'b0, 0, '0, 0, 1'b0); drain();

      // T5: reset in the middle of a packet with a record held
      rdy_mode = 2;
      drive_beat(7, 1'b0, 1'b0, 0);
      @(negedge clk);
      bus.i_tvalid = 1'b0;
      reset_n = 1'b0;
      mon_en  = 1'b0;
      @(negedge clk);
      check("midrst_ovalid", 64'(bus.o_tvalid), 64'(0));
      check("midrst_odata", 64'(bus.o_tdata), 64'(0));
      reset_n = 1'b1;
      rdy_mode = 1;
      exp_q.delete();
      cfg_thr = '0; cfg_bpc = 1;
      @(negedge clk);
      mon_en = 1'b1;
      pkt = '{4, 9};
      model_packet(); send_pkt(1'b0, 0, '0, 0, 1'b0); drain();

      // channel index wrap within one long packet
      rdy_mode = 0;
      set_cfg(128, 1);
      pkt.delete();
      for (int i = 0; i < 260; i++) pkt.push_back($urandom_range(0, 255));
      model_packet(); send_pkt(1'b0, 0, '0, 0, 1'b0); drain();

      // randomized packets and config timing
      for (int p = 0; p < 40; p++) begin
         int m;
         int len;
         logic [WIDTH-1:0] nthr;
         int nbpc;
         m    = $urandom_range(0, 3);
         len  = $urandom_range(1, 20);
         nthr = $urandom_range(0, 255);
         nbpc = $urandom_range(0, 6);
         case ($urandom_range(0, 2))
            0:       rdy_mode = 0;
            1:       rdy_mode = 1;
            default: rdy_mode = 3;
         endcase
         pkt.delete();
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 5) == 0) pkt.push_back(cfg_thr);
            else pkt.push_back($urandom_range(0, 255));
         end
         if (m == 1) set_cfg(nthr, nbpc);
         if (m == 2) begin
            cfg_thr = nthr;
            cfg_bpc = nbpc;
         end
         model_packet();
         send_pkt(m == 2, (m == 3 && len > 1) ? len / 2 : 0, nthr, nbpc, 1'b1);
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
